// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave over a preloadable 64-bit word store, one burst in flight at a time.
// Optional WRAP burst support is enabled by defining AXI_RD_WRAP_EN.
module axi_rd_responder #(
    parameter int unsigned ID_WIDTH     = 13,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data
);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned WIDX_W = ADDR_WIDTH - 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [ID_WIDTH-1:0]     id_q, id_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [7:0]              len_q, len_n;
    logic [7:0]              beat_q, beat_n;
    logic [2:0]              size_q, size_n;
    logic [1:0]              burst_q, burst_n;
    logic                    err_q, err_n;
    logic                    arready_n, rvalid_n, rlast_n;
    logic [1:0]              rresp_n;
    logic [DATA_WIDTH-1:0]   rdata_n;
    logic [ID_WIDTH-1:0]     rid_n;
    logic                    load_c;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    in_range_c;
    logic [DATA_WIDTH-1:0]   word_c;
    logic [ADDR_WIDTH-1:0]   step_c, next_addr_c;
    logic                    req_err_c;

    assign in_range_c = addr_q[ADDR_WIDTH-1:3] < WIDX_W'(MEM_WORDS);
    assign word_c     = mem[addr_q[3 +: IDX_W]];
    assign step_c     = ADDR_WIDTH'(1) << size_q;

`ifdef AXI_RD_WRAP_EN
    logic [ADDR_WIDTH-1:0]   wrap_mask_c;
    assign wrap_mask_c = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
`endif

    // Address of the beat after the one being loaded
    always_comb begin
        next_addr_c = addr_q;
        if (burst_q == BURST_INCR) begin
            next_addr_c = addr_q + step_c;
        end
`ifdef AXI_RD_WRAP_EN
        else if (burst_q == BURST_WRAP) begin
            next_addr_c = (addr_q & ~wrap_mask_c) | ((addr_q + step_c) & wrap_mask_c);
        end
`endif
    end

    // Requests that get SLVERR on every beat
    always_comb begin
        req_err_c = (s_axi_arsize > 3'd3) || (s_axi_arburst == 2'b11);
`ifdef AXI_RD_WRAP_EN
        if (s_axi_arburst == BURST_WRAP &&
            !(s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 ||
              s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15)) begin
            req_err_c = 1'b1;
        end
`else
        if (s_axi_arburst == BURST_WRAP) begin
            req_err_c = 1'b1;
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        id_n     = id_q;
        addr_n   = addr_q;
        len_n    = len_q;
        size_n   = size_q;
        burst_n  = burst_q;
        err_n    = err_q;
        beat_n   = beat_q;
        rvalid_n = s_axi_rvalid;
        rdata_n  = s_axi_rdata;
        rresp_n  = s_axi_rresp;
        rlast_n  = s_axi_rlast;
        rid_n    = s_axi_rid;
        load_c   = 1'b0;

        case (state)
            S_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    id_n    = s_axi_arid;
                    addr_n  = s_axi_araddr;
                    len_n   = s_axi_arlen;
                    size_n  = s_axi_arsize;
                    burst_n = s_axi_arburst;
                    err_n   = req_err_c;
                    beat_n  = 8'd0;
                    if (READ_LATENCY == 0) begin
                        state_n = S_BURST;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = 4'(READ_LATENCY);
                    end
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = S_BURST;
                end
            end
            S_BURST: begin
                if (!s_axi_rvalid) begin
                    load_c = 1'b1;
                end else if (s_axi_rready) begin
                    if (s_axi_rlast) begin
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                        state_n  = S_IDLE;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (load_c) begin
            rvalid_n = 1'b1;
            rid_n    = id_q;
            rlast_n  = (beat_q == len_q);
            beat_n   = beat_q + 8'd1;
            addr_n   = next_addr_c;
            if (err_q) begin
                rresp_n = RESP_SLVERR;
                rdata_n = '0;
            end else if (!in_range_c) begin
                rresp_n = RESP_DECERR;
                rdata_n = '0;
            end else begin
                rresp_n = RESP_OKAY;
                rdata_n = word_c;
            end
        end

        arready_n = (state_n == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            beat_q        <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            id_q          <= id_n;
            addr_q        <= addr_n;
            len_q         <= len_n;
            size_q        <= size_n;
            burst_q       <= burst_n;
            err_q         <= err_n;
            beat_q        <= beat_n;
            s_axi_arready <= arready_n;
            s_axi_rvalid  <= rvalid_n;
            s_axi_rdata   <= rdata_n;
            s_axi_rresp   <= rresp_n;
            s_axi_rlast   <= rlast_n;
            s_axi_rid     <= rid_n;
        end
    end

    // Backdoor preload port; contents survive reset
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed self-checking bench for axi_rd_responder; expectations are hand-computed.
module tb_axi_rd_responder;
    localparam int unsigned ID_W   = 13;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned WORDS  = 1024;
    localparam int unsigned LAT    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;
    logic               ld_en;
    logic [9:0]         ld_addr;
    logic [DATA_W-1:0]  ld_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_data [16];
    logic [1:0]  exp_resp [16];
    logic [3:0]  pat;
    int          beat;

    localparam logic [63:0] TOP_WORD = 64'hFEED_0000_1234_5678;

    axi_rd_responder #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W),
        .MEM_WORDS(WORDS), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_ar(input logic [ID_W-1:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        check("arready_before_ar", 64'(arready), 64'd1);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        for (int k = 0; k < 40 && !rvalid; k++) tick();
        check("rvalid_within_budget", 64'(rvalid), 64'd1);
    endtask

    // Expects rready held high; walks n beats against exp_data/exp_resp
    task automatic check_beats(input int n, input logic [ID_W-1:0] id);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rvalid[%0d]", i), 64'(rvalid), 64'd1);
            check($sformatf("rdata[%0d]", i), rdata, exp_data[i]);
            check($sformatf("rresp[%0d]", i), 64'(rresp), 64'(exp_resp[i]));
            check($sformatf("rlast[%0d]", i), 64'(rlast), 64'(i == n - 1));
            check($sformatf("rid[%0d]", i), 64'(rid), 64'(id));
            tick();
        end
        check("rvalid_after_burst", 64'(rvalid), 64'd0);
        check("arready_after_burst", 64'(arready), 64'd1);
    endtask

    initial begin
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_rresp", 64'(rresp), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_rid", 64'(rid), 64'd0);

        // Preload words 0..7 = 0xA0..0xA7 and the last word
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 10'(i); ld_data = 64'hA0 + 64'(i);
            tick();
        end
        ld_addr = 10'd1023; ld_data = TOP_WORD;
        tick();
        ld_en = 1'b0;

        #3 reset = 1'b1;
        check("arready_still_low_before_edge", 64'(arready), 64'd0);
        tick();
        check("arready_after_release", 64'(arready), 64'd1);

        // Basic INCR burst with latency check
        rready = 1'b1;
        issue_ar(13'h5, 64'h0, 8'd3, 3'd3, 2'b01);
        check("lat_cycle0", 64'(rvalid), 64'd0);
        check("lat_arready_busy", 64'(arready), 64'd0);
        tick();
        check("lat_cycle1", 64'(rvalid), 64'd0);
        tick();
        check("lat_cycle2", 64'(rvalid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'hA0 + 64'(i); exp_resp[i] = 2'b00;
        end
        check_beats(4, 13'h5);

        // Same burst under rready pattern 1,0,0,1
        rready = 1'b0;
        pat = 4'b1001;
        issue_ar(13'h5, 64'h0, 8'd3, 3'd3, 2'b01);
        wait_rvalid();
        beat = 0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            check("stall_rvalid", 64'(rvalid), 64'd1);
            check($sformatf("stall_rdata[%0d]", beat), rdata, 64'hA0 + 64'(beat));
            check($sformatf("stall_rlast[%0d]", beat), 64'(rlast), 64'(beat == 3));
            check("stall_rid", 64'(rid), 64'h5);
            rready = pat[c % 4];
            tick();
            if (rready) beat++;
        end
        check("stall_beats_done", 64'(beat), 64'd4);
        check("stall_rvalid_end", 64'(rvalid), 64'd0);
        rready = 1'b1;
        tick();

        // Burst running off the end of memory
        issue_ar(13'h7, 64'h1FF8, 8'd1, 3'd3, 2'b01);
        wait_rvalid();
        exp_data[0] = TOP_WORD; exp_resp[0] = 2'b00;
        exp_data[1] = 64'd0;    exp_resp[1] = 2'b11;
        check_beats(2, 13'h7);

        // Oversized arsize
        issue_ar(13'h9, 64'h0, 8'd0, 3'd4, 2'b01);
        wait_rvalid();
        exp_data[0] = 64'd0; exp_resp[0] = 2'b10;
        check_beats(1, 13'h9);

        // Reset during beat 2 of a len-7 burst
        issue_ar(13'h3, 64'h0, 8'd7, 3'd3, 2'b01);
        wait_rvalid();
        check("rst_burst_b0", rdata, 64'hA0);
        tick();
        check("rst_burst_b1", rdata, 64'hA1);
        tick();
        check("rst_burst_b2", rdata, 64'hA2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        check("async_rst_arready", 64'(arready), 64'd0);
        check("async_rst_rdata", rdata, 64'd0);
        #2 reset = 1'b1;
        tick();
        check("arready_after_midburst_rst", 64'(arready), 64'd1);
        check("rvalid_after_midburst_rst", 64'(rvalid), 64'd0);
        issue_ar(13'h4, 64'h10, 8'd1, 3'd3, 2'b01);
        wait_rvalid();
        exp_data[0] = 64'hA2; exp_resp[0] = 2'b00;
        exp_data[1] = 64'hA3; exp_resp[1] = 2'b00;
        check_beats(2, 13'h4);

        // WRAP burst at 0x18
        issue_ar(13'h6, 64'h18, 8'd3, 3'd3, 2'b10);
        wait_rvalid();
`ifdef AXI_RD_WRAP_EN
        exp_data[0] = 64'hA3; exp_data[1] = 64'hA0; exp_data[2] = 64'hA1; exp_data[3] = 64'hA2;
        for (int i = 0; i < 4; i++) exp_resp[i] = 2'b00;
`else
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'd0; exp_resp[i] = 2'b10;
        end
`endif
        check_beats(4, 13'h6);

        // A request held during a burst is taken only after the burst ends
        arid = 13'h1; araddr = 64'h0; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
        arvalid = 1'b1;
        tick();
        arid = 13'h2; araddr = 64'h8;
        wait_rvalid();
        check("held_ar_first_rid", 64'(rid), 64'h1);
        check("held_ar_first_data", rdata, 64'hA0);
        check("held_ar_busy", 64'(arready), 64'd0);
        tick();
        check("held_ar_idle", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        wait_rvalid();
        check("held_ar_second_rid", 64'(rid), 64'h2);
        check("held_ar_second_data", rdata, 64'hA1);
        check("held_ar_second_last", 64'(rlast), 64'd1);
        tick();
        check("held_ar_done", 64'(rvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
